// File: rtl/accel_pkg.sv
// Shared definitions for the UART command path: command codes, packet size
// and the assembler state encoding. Also imported by the CSR/buffer dispatcher.
// No ports; types, constants and a command-decode helper only.
package accel_pkg;

  localparam logic [7:0] CMD_CSR_WR   = 8'h00;
  localparam logic [7:0] CMD_BUF_WR_A = 8'h20;
  localparam logic [7:0] CMD_BUF_WR_B = 8'h30;
  localparam logic [7:0] CMD_START    = 8'h50;
  localparam logic [7:0] CMD_STATUS   = 8'h70;

  // cmd, addr[7:0], addr[15:8], data[7:0] .. data[31:24]
  localparam int PKT_BYTES = 7;

  typedef enum logic {
    ST_IDLE    = 1'b0,
    ST_COLLECT = 1'b1
  } asm_state_e;

  function automatic logic cmd_is_valid(input logic [7:0] cmd);
    logic ok;
    ok = 1'b0;
    case (cmd)
      CMD_CSR_WR, CMD_BUF_WR_A, CMD_BUF_WR_B, CMD_START, CMD_STATUS: ok = 1'b1;
      default: ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/pkt_assembler.sv
// Purpose: assembles 7 UART bytes (cmd, addr LE, data LE) into one command packet.
// Latency: pkt_valid rises 1 cycle after the rx_valid of the 7th byte.
// Backpressure: one held output slot plus the assembly registers as slack; a packet
//   completing while the slot is held and not accepted is dropped (overrun pulse).
// Ports: clk/rst (sync, active-high); rx_valid/rx_data byte strobe (no backpressure);
//   pkt_valid/pkt_ready handshake with pkt_cmd/pkt_addr/pkt_data; busy while
//   collecting; frame_err/cmd_err/overrun one-cycle error pulses; err_cnt saturating.
module pkt_assembler
  import accel_pkg::*;
#(
  parameter int TIMEOUT_CYC = 8680,
  parameter int CNT_W       = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             rx_valid,
  input  logic [7:0]       rx_data,
  output logic             pkt_valid,
  input  logic             pkt_ready,
  output logic [7:0]       pkt_cmd,
  output logic [15:0]      pkt_addr,
  output logic [31:0]      pkt_data,
  output logic             busy,
  output logic             frame_err,
  output logic             cmd_err,
  output logic             overrun,
  output logic [CNT_W-1:0] err_cnt
);

  localparam int              GAP_W    = $clog2(TIMEOUT_CYC + 1);
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYC - 1);
  localparam logic [2:0]      LAST_POS = 3'(PKT_BYTES - 1);

  asm_state_e       r_state;
  logic [2:0]       r_byte_cnt;
  logic [GAP_W-1:0] r_gap;
  logic [7:0]       r_cmd;
  logic [15:0]      r_addr;
  // Only the low three data bytes are buffered; the top byte arrives with completion.
  logic [23:0]      r_data;

  logic             r_pkt_valid;
  logic [7:0]       r_pkt_cmd;
  logic [15:0]      r_pkt_addr;
  logic [31:0]      r_pkt_data;
  logic             r_frame_err;
  logic             r_cmd_err;
  logic             r_overrun;
  logic [CNT_W-1:0] r_err_cnt;

  logic w_done;
  logic w_cmd_ok;
  logic w_slot_free;
  logic w_load;
  logic w_cmd_err;
  logic w_overrun;
  logic w_timeout;
  logic w_any_err;

  assign w_done      = (r_state == ST_COLLECT) && rx_valid && (r_byte_cnt == LAST_POS);
  assign w_cmd_ok    = cmd_is_valid(r_cmd);
  // Slot counts as free when it is being emptied by a transfer this same cycle.
  assign w_slot_free = !r_pkt_valid || pkt_ready;
  assign w_load      = w_done && w_cmd_ok && w_slot_free;
  assign w_cmd_err   = w_done && !w_cmd_ok;
  assign w_overrun   = w_done && w_cmd_ok && !w_slot_free;
  // A byte arriving in the timeout cycle wins over the timeout.
  assign w_timeout   = (r_state == ST_COLLECT) && !rx_valid && (r_gap == GAP_LAST);
  assign w_any_err   = w_timeout || w_cmd_err || w_overrun;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= ST_IDLE;
      r_byte_cnt  <= '0;
      r_gap       <= '0;
      r_cmd       <= '0;
      r_addr      <= '0;
      r_data      <= '0;
      r_pkt_valid <= 1'b0;
      r_pkt_cmd   <= '0;
      r_pkt_addr  <= '0;
      r_pkt_data  <= '0;
      r_frame_err <= 1'b0;
      r_cmd_err   <= 1'b0;
      r_overrun   <= 1'b0;
      r_err_cnt   <= '0;
    end else begin
      r_frame_err <= w_timeout;
      r_cmd_err   <= w_cmd_err;
      r_overrun   <= w_overrun;
      if (w_any_err && (r_err_cnt != '1)) begin
        r_err_cnt <= r_err_cnt + 1'b1;
      end

      if (w_load) begin
        r_pkt_valid <= 1'b1;
        r_pkt_cmd   <= r_cmd;
        r_pkt_addr  <= r_addr;
        r_pkt_data  <= {rx_data, r_data};
      end else if (r_pkt_valid && pkt_ready) begin
        r_pkt_valid <= 1'b0;
      end

      case (r_state)
        ST_IDLE: begin
          if (rx_valid) begin
            r_cmd      <= rx_data;
            r_byte_cnt <= 3'd1;
            r_gap      <= '0;
            r_state    <= ST_COLLECT;
          end
        end
        ST_COLLECT: begin
          if (rx_valid) begin
            r_gap <= '0;
            case (r_byte_cnt)
              3'd1:    r_addr[7:0]   <= rx_data;
              3'd2:    r_addr[15:8]  <= rx_data;
              3'd3:    r_data[7:0]   <= rx_data;
              3'd4:    r_data[15:8]  <= rx_data;
              3'd5:    r_data[23:16] <= rx_data;
              default: ;
            endcase
            if (w_done) begin
              r_byte_cnt <= '0;
              r_state    <= ST_IDLE;
            end else begin
              r_byte_cnt <= r_byte_cnt + 3'd1;
            end
          end else if (w_timeout) begin
            r_gap      <= '0;
            r_byte_cnt <= '0;
            r_state    <= ST_IDLE;
          end else begin
            r_gap <= r_gap + 1'b1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign pkt_valid = r_pkt_valid;
  assign pkt_cmd   = r_pkt_cmd;
  assign pkt_addr  = r_pkt_addr;
  assign pkt_data  = r_pkt_data;
  assign busy      = (r_state == ST_COLLECT);
  assign frame_err = r_frame_err;
  assign cmd_err   = r_cmd_err;
  assign overrun   = r_overrun;
  assign err_cnt   = r_err_cnt;

endmodule

// File: tb/tb_pkt_assembler.sv
// Directed bench for pkt_assembler: hand-computed packets, handshake, overrun,
// timeout, unknown command and mid-packet reset.
module tb_pkt_assembler;

  localparam int TO    = 20;
  localparam int CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             rx_valid;
  logic [7:0]       rx_data;
  logic             pkt_valid;
  logic             pkt_ready;
  logic [7:0]       pkt_cmd;
  logic [15:0]      pkt_addr;
  logic [31:0]      pkt_data;
  logic             busy;
  logic             frame_err;
  logic             cmd_err;
  logic             overrun;
  logic [CNT_W-1:0] err_cnt;

  int n_chk = 0;
  int n_bad = 0;
  int fe_cnt = 0;
  int ce_cnt = 0;
  int ov_cnt = 0;
  logic [55:0] got_q[$];

  always #5 clk = ~clk;

  pkt_assembler #(.TIMEOUT_CYC(TO), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .rst       (rst),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .pkt_valid (pkt_valid),
    .pkt_ready (pkt_ready),
    .pkt_cmd   (pkt_cmd),
    .pkt_addr  (pkt_addr),
    .pkt_data  (pkt_data),
    .busy      (busy),
    .frame_err (frame_err),
    .cmd_err   (cmd_err),
    .overrun   (overrun),
    .err_cnt   (err_cnt)
  );

  // Inputs change 1 ns after posedge, so the negedge sees stable handshake values.
  always @(negedge clk) begin
    if ((pkt_valid === 1'b1) && (pkt_ready === 1'b1)) got_q.push_back({pkt_cmd, pkt_addr, pkt_data});
    if (frame_err === 1'b1) fe_cnt++;
    if (cmd_err === 1'b1) ce_cnt++;
    if (overrun === 1'b1) ov_cnt++;
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Bytes p[55:48] first; sends byte positions from..to back-to-back.
  task automatic send_bytes(input logic [55:0] p, input int from, input int to);
    for (int i = from; i <= to; i++) begin
      rx_valid = 1'b1;
      rx_data  = p[55-8*i -: 8];
      tick();
    end
    rx_valid = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int fe0, sum0;
    logic [55:0] pa, pb;
    pa = 56'h20_00_00_08_07_06_05;  // BUF_WR_A addr 0000 data 05060708
    pb = 56'h20_01_00_10_0F_0E_0D;  // BUF_WR_A addr 0001 data 0D0E0F10

    rst = 1'b1; rx_valid = 1'b0; rx_data = 8'h00; pkt_ready = 1'b0;
    repeat (3) tick();
    chk("rst_pkt_valid", pkt_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err_cnt", err_cnt, 0);
    chk("rst_fields", {pkt_cmd, pkt_addr, pkt_data}, 0);
    chk("rst_pulses", {frame_err, cmd_err, overrun}, 0);
    rst = 1'b0;

    // Basic CSR_WR packet, consumer always ready.
    pkt_ready = 1'b1;
    send_bytes(56'h00_08_00_08_00_00_00, 0, 2);
    chk("p1_busy_mid", busy, 1);
    send_bytes(56'h00_08_00_08_00_00_00, 3, 6);
    chk("p1_valid", pkt_valid, 1);
    chk("p1_busy_end", busy, 0);
    chk("p1_fields", {pkt_cmd, pkt_addr, pkt_data}, 56'h00_0008_00000008);
    tick();
    chk("p1_valid_1cyc", pkt_valid, 0);
    chk("p1_nxfer", got_q.size(), 1);

    // Overrun: second packet completes while first held.
    got_q.delete();
    pkt_ready = 1'b0;
    send_bytes(pa, 0, 6);
    send_bytes(pb, 0, 6);
    chk("ov_pulse", overrun, 1);
    chk("ov_held_valid", pkt_valid, 1);
    chk("ov_held_fields", {pkt_cmd, pkt_addr, pkt_data}, 56'h20_0000_05060708);
    chk("ov_err_cnt", err_cnt, 1);
    tick();
    chk("ov_pulse_end", overrun, 0);
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
    chk("ov_drained", pkt_valid, 0);
    chk("ov_nxfer", got_q.size(), 1);
    chk("ov_xfer0", got_q[0], 56'h20_0000_05060708);

    // Slot freed in the same cycle the second packet completes.
    got_q.delete();
    send_bytes(pa, 0, 6);
    send_bytes(pb, 0, 5);
    rx_valid = 1'b1; rx_data = 8'h0D; pkt_ready = 1'b1;
    tick();
    rx_valid = 1'b0; pkt_ready = 1'b0;
    chk("same_valid", pkt_valid, 1);
    chk("same_fields", {pkt_cmd, pkt_addr, pkt_data}, 56'h20_0001_0D0E0F10);
    chk("same_no_ov", overrun, 0);
    pkt_ready = 1'b1;
    tick();
    pkt_ready = 1'b0;
    chk("same_nxfer", got_q.size(), 2);
    chk("same_xfer0", got_q[0], 56'h20_0000_05060708);
    chk("same_xfer1", got_q[1], 56'h20_0001_0D0E0F10);
    chk("same_ov_total", ov_cnt, 1);
    chk("same_err_cnt", err_cnt, 1);

    // Inter-byte timeout after 3 bytes.
    pkt_ready = 1'b1;
    send_bytes(56'h30_11_22_33_00_00_00, 0, 2);
    repeat (TO - 1) tick();
    chk("to_not_yet", {busy, frame_err}, 2'b10);
    tick();
    chk("to_pulse", {busy, frame_err}, 2'b01);
    tick();
    chk("to_pulse_end", frame_err, 0);
    chk("to_err_cnt", err_cnt, 2);
    send_bytes(56'h50_00_00_01_00_00_00, 0, 6);
    chk("to_next_valid", pkt_valid, 1);
    chk("to_next_fields", {pkt_cmd, pkt_addr, pkt_data}, 56'h50_0000_00000001);
    tick();

    // Byte arriving exactly in the timeout cycle is accepted.
    fe0 = fe_cnt;
    send_bytes(56'h70_34_12_78_56_34_12, 0, 2);
    repeat (TO - 1) tick();
    send_bytes(56'h70_34_12_78_56_34_12, 3, 6);
    chk("edge_valid", pkt_valid, 1);
    chk("edge_fields", {pkt_cmd, pkt_addr, pkt_data}, 56'h70_1234_12345678);
    chk("edge_no_fe", fe_cnt - fe0, 0);
    tick();

    // Unknown command.
    send_bytes(56'h41_00_00_00_00_00_00, 0, 6);
    chk("cmd_err_pulse", cmd_err, 1);
    chk("cmd_err_no_valid", pkt_valid, 0);
    chk("cmd_err_cnt", err_cnt, 3);
    tick();
    chk("cmd_err_end", cmd_err, 0);
    chk("cmd_err_total", ce_cnt, 1);

    // Reset with a packet held and another partially collected.
    pkt_ready = 1'b0;
    send_bytes(56'h00_08_00_08_00_00_00, 0, 6);
    send_bytes(56'h50_AA_BB_CC_DD_EE_FF, 0, 3);
    sum0 = fe_cnt + ce_cnt + ov_cnt;
    rst = 1'b1;
    tick();
    tick();
    chk("mrst_valid_busy", {pkt_valid, busy}, 0);
    chk("mrst_fields", {pkt_cmd, pkt_addr, pkt_data}, 0);
    chk("mrst_err_cnt", err_cnt, 0);
    rst = 1'b0;
    pkt_ready = 1'b1;
    send_bytes(56'h30_CD_AB_EF_BE_AD_DE, 0, 6);
    chk("mrst_no_pulse", fe_cnt + ce_cnt + ov_cnt - sum0, 0);
    chk("mrst_next_valid", pkt_valid, 1);
    chk("mrst_next_fields", {pkt_cmd, pkt_addr, pkt_data}, 56'h30_ABCD_DEADBEEF);
    chk("mrst_next_err_cnt", err_cnt, 0);
    tick();

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end

endmodule

// File: doc/pkt_assembler.md
PKT_ASSEMBLER -- requirements
Module: pkt_assembler

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 8680, giving the inter-byte timeout in clk cycles (20 bit times at 115200 baud, 50 MHz).
REQ-002 SHALL have parameter CNT_W, default 8, giving the width of the saturating error counter.
REQ-003 SHALL have port clk, input, 1, the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1, the reset: synchronous, active-high.
REQ-005 SHALL have port rx_valid, input, 1, a one-cycle strobe from the UART byte receiver; it has no backpressure.
REQ-006 SHALL have port rx_data, input, 8, the received byte, qualified by rx_valid.
REQ-007 SHALL have port pkt_valid, output, 1, meaning an assembled packet is held.
REQ-008 SHALL have port pkt_ready, input, 1, the consumer (CSR/buffer dispatcher) accept signal.
REQ-009 SHALL have port pkt_cmd, output, 8, the packet command byte.
REQ-010 SHALL have port pkt_addr, output, 16, the packet address.
REQ-011 SHALL have port pkt_data, output, 32, the packet payload.
REQ-012 SHALL have port busy, output, 1, high while a packet is partially collected.
REQ-013 SHALL have port frame_err, output, 1, a one-cycle pulse on inter-byte timeout.
REQ-014 SHALL have port cmd_err, output, 1, a one-cycle pulse on an unknown command.
REQ-015 SHALL have port overrun, output, 1, a one-cycle pulse when a completed packet is dropped because the output slot is full.
REQ-016 SHALL have port err_cnt, output, CNT_W, counting frame_err, cmd_err and overrun events; it saturates at all-ones.

Function
REQ-017 SHALL assemble a 7-byte packet in this order: cmd, addr[7:0], addr[15:8], data[7:0], data[15:8], data[23:16], data[31:24].
REQ-018 SHALL use two states: IDLE (byte_cnt=0) and COLLECT (byte_cnt 1..6).
REQ-019 In IDLE, rx_valid SHALL store the cmd byte, set byte_cnt=1 and enter COLLECT.
REQ-020 In COLLECT, each rx_valid SHALL store the byte at position byte_cnt and increment byte_cnt.
REQ-021 The 7th byte SHALL complete the packet and return the block to IDLE.
REQ-022 Valid commands SHALL be 0x00 (CSR_WR), 0x20 (BUF_WR_A), 0x30 (BUF_WR_B), 0x50 (START) and 0x70 (STATUS).
REQ-023 On completion with an unknown cmd, the packet SHALL be discarded and cmd_err SHALL pulse in the cycle after the 7th byte.
REQ-024 On completion with a valid cmd and the slot free, or being freed that same cycle (pkt_valid&&pkt_ready), the packet SHALL load into the output registers and pkt_valid SHALL be 1 in the next cycle.
REQ-025 Latency SHALL be exactly 1 cycle from the rx_valid of the 7th byte to pkt_valid.
REQ-026 pkt_cmd, pkt_addr and pkt_data SHALL be stable while pkt_valid=1 and pkt_ready=0.
REQ-027 A transfer SHALL occur on pkt_valid&&pkt_ready; pkt_valid SHALL clear in the next cycle unless a new packet loads in the same cycle, in which case pkt_valid stays 1 with the new contents.
REQ-028 While the slot is held, assembly of the next packet SHALL continue into the shift register (one packet of slack).
REQ-029 If the next packet completes while pkt_valid=1 and pkt_ready=0, it SHALL be dropped, overrun SHALL pulse and the held packet SHALL be unchanged.
REQ-030 In COLLECT, a gap counter SHALL clear on each rx_valid and increment otherwise.
REQ-031 When the gap counter reaches TIMEOUT_CYC-1 without rx_valid, the partial packet SHALL be discarded, frame_err SHALL pulse, and the block SHALL return to IDLE.
REQ-032 If rx_valid coincides with the timeout cycle, the byte SHALL be accepted and no timeout taken.
REQ-033 The gap counter SHALL NOT run in IDLE; idle gaps of any length SHALL be legal.
REQ-034 busy SHALL equal (state==COLLECT).
REQ-035 err_cnt SHALL increment by 1 per cycle in which any error pulse is asserted; simultaneous errors count once.

Reset
REQ-036 While rst=1, the following SHALL be 0: state=IDLE, byte_cnt, gap counter, pkt_valid, pkt_cmd, pkt_addr, pkt_data, busy, frame_err, cmd_err, overrun and err_cnt.
REQ-037 rst asserted mid-packet SHALL discard the partial packet and any held packet, with no error pulse.
REQ-038 The first byte after rst deasserts SHALL be treated as a cmd byte.

Structure
REQ-039 The CMD_* codes, PKT_BYTES=7 and the state enum SHALL live in shared package accel_pkg, which is also used by the dispatcher.
REQ-040 The block SHALL be a single module with no sub-modules; the gap counter SHALL be inline.

Verification
REQ-041 Bytes 00 08 00 08 00 00 00 with pkt_ready=1 -> pkt_valid for 1 cycle, 1 cycle after the last byte, with cmd=0x00, addr=0x0008, data=0x00000008.
REQ-042 Two BUF_WR_A packets (addr 0x0000 data 0x05060708, then addr 0x0001 data 0x0D0E0F10) with pkt_ready=0 until after the 2nd completes -> 1st held intact, overrun=1 once, err_cnt=1, 2nd lost.
REQ-043 With the same pkt_ready=0 hold as REQ-042, raising pkt_ready in the same cycle the 2nd packet completes -> both delivered in order, no overrun.
REQ-044 3 bytes, then a silence of TIMEOUT_CYC cycles -> frame_err pulse, busy=0; a following full packet 50 00 00 01 00 00 00 -> cmd=0x50, data=0x00000001.
REQ-045 Packet with cmd 0x41 -> cmd_err pulse, no pkt_valid, err_cnt+1.
REQ-046 rst asserted after byte 4 -> all outputs 0; the next 7 bytes form a correct packet.
